// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with count and threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  // Handshake: wr acts as push-valid with ready = !full (or a pop in the same
  // cycle); rd acts as pop-valid with ready = !empty. Unaccepted requests are dropped.
  assign do_pop  = rd && (count_q != '0);
  assign do_push = wr && ((count_q != DEPTH_C) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = w_data;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign r_data       = mem_q[rd_ptr_q];
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A push is only dropped when full with no pop; a pop is dropped whenever empty.
  always_comb begin
    overflow_d  = overflow_q  || (wr && (count_q == DEPTH_C) && !rd);
    underflow_d = underflow_q || (rd && (count_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: table of single-cycle vectors, then a
// pointer-wrap sequence checked against an expected-data queue.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .AF_LEVEL  (3),
    .AE_LEVEL  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] wd;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       chk_r;
    logic [7:0] rdata;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vq[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic w, input logic r, input logic [7:0] wd,
                     input logic [2:0] cnt, input logic f, input logic e, input logic af,
                     input logic ae, input logic cr, input logic [7:0] rdat,
                     input logic ovf, input logic unf);
    vec_t v;
    v = '{rst, w, r, wd, cnt, f, e, af, ae, cr, rdat, ovf, unf};
    vq.push_back(v);
  endtask

  // Driver: present inputs, take one rising edge, settle before sampling.
  task automatic drive(input logic rst, input logic w, input logic r, input logic [7:0] wd);
    reset  = rst;
    wr     = w;
    rd     = r;
    w_data = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] pat [10];
    logic [7:0] nxt;
    int         guard;

    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;

    //   rst wr rd wd     cnt f e af ae chk_r rdata ovf unf
    add(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h00, 0, 0); // reset
    add(0, 1, 0, 8'h11, 1, 0, 0, 0, 1, 1, 8'h11, 0, 0); // fill
    add(0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 1, 8'h11, 0, 0);
    add(0, 1, 0, 8'h33, 3, 0, 0, 1, 0, 1, 8'h11, 0, 0);
    add(0, 1, 0, 8'h44, 4, 1, 0, 1, 0, 1, 8'h11, 0, 0);
    add(0, 1, 0, 8'h55, 4, 1, 0, 1, 0, 1, 8'h11, 1, 0); // dropped push
    add(0, 1, 1, 8'h5A, 4, 1, 0, 1, 0, 1, 8'h22, 1, 0); // push+pop when full
    add(0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 1, 8'h33, 1, 0); // drain
    add(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 8'h44, 1, 0);
    add(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 8'h5A, 1, 0);
    add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 1, 0);
    add(0, 1, 1, 8'h66, 1, 0, 0, 0, 1, 1, 8'h66, 1, 1); // push+pop when empty
    add(0, 1, 0, 8'h77, 2, 0, 0, 0, 0, 1, 8'h66, 1, 1);
    add(0, 1, 0, 8'h88, 3, 0, 0, 1, 0, 1, 8'h66, 1, 1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h00, 0, 0); // reset with data held
    add(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h00, 0, 0);
    add(1, 1, 1, 8'h99, 0, 0, 1, 0, 1, 1, 8'h00, 0, 0); // reset wins over wr/rd
    add(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h00, 0, 1); // pop alone when empty

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].wr, vq[i].rd, vq[i].wd);
      chk($sformatf("v%0d count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("v%0d full", i), 32'(full), 32'(vq[i].full));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(vq[i].empty));
      chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vq[i].af));
      chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vq[i].ae));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vq[i].ovf & FLAGS_ON));
      chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(vq[i].unf & FLAGS_ON));
      if (vq[i].chk_r) begin
        chk($sformatf("v%0d r_data", i), 32'(r_data), 32'(vq[i].rdata));
      end
    end

    // Pointer wrap: interleaved traffic keeping count within 1..3.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.delete();
    nxt = 8'hA0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, nxt);
      exp_q.push_back(nxt);
      nxt = nxt + 8'd1;
    end
    pat = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 10; i++) begin
      if (pat[i][0]) begin
        chk($sformatf("wrap%0d head", i), 32'(r_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (pat[i][1]) begin
        exp_q.push_back(nxt);
      end
      drive(1'b0, pat[i][1], pat[i][0], nxt);
      nxt = nxt + 8'd1;
      chk($sformatf("wrap%0d count", i), 32'(count), 32'(exp_q.size()));
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 8) begin
      chk($sformatf("drain%0d head", guard), 32'(r_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      guard++;
    end
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
